// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: turns 3-byte (opcode, A, B) RX frames into ALU operations and returns the result as two TX bytes
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_D,
  input  logic                  RX_D_VLD,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0] TX_D,
  output logic                  TX_D_VLD,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  ERR
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, SEND_LO, SEND_HI} state_t;
  state_t state, state_nx;
  logic [OUT_WIDTH-1:0] result;
  logic [CW-1:0] cnt;
  logic err_nx;
  logic op_ok;
  assign op_ok = RX_D[DATA_WIDTH-1:FUN_WIDTH] == '0;
  always_comb begin
    state_nx = state;
    err_nx = 1'b0;
    case (state)
      IDLE: begin
        state_nx = (RX_D_VLD && op_ok) ? GET_A : IDLE;
        err_nx = RX_D_VLD && !op_ok;
      end
      GET_A: state_nx = RX_D_VLD ? GET_B : GET_A;
      GET_B: state_nx = RX_D_VLD ? EXEC : GET_B;
      EXEC: begin
        // a valid result beats a timeout landing in the same cycle
        state_nx = ALU_OUT_VLD ? SEND_LO : (cnt == CW'(TIMEOUT - 1)) ? IDLE : EXEC;
        err_nx = RX_D_VLD || (!ALU_OUT_VLD && cnt == CW'(TIMEOUT - 1));
      end
      SEND_LO: begin
        state_nx = TX_READY ? SEND_HI : SEND_LO;
        err_nx = RX_D_VLD;
      end
      SEND_HI: begin
        state_nx = TX_READY ? IDLE : SEND_HI;
        err_nx = RX_D_VLD;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      ERR <= 1'b0;
      ALU_FUN <= '0;
      ALU_A <= '0;
      ALU_B <= '0;
      result <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      ERR <= err_nx;
      if (state == IDLE && RX_D_VLD && op_ok) ALU_FUN <= RX_D[FUN_WIDTH-1:0];
      if (state == GET_A && RX_D_VLD) ALU_A <= RX_D;
      if (state == GET_B && RX_D_VLD) begin
        ALU_B <= RX_D;
        cnt <= '0;
      end
      if (state == EXEC) cnt <= cnt + 1'b1;
      if (state == EXEC && ALU_OUT_VLD) result <= ALU_OUT;
    end
  end
  assign ALU_EN = state == EXEC;
  assign TX_D_VLD = state == SEND_LO || state == SEND_HI;
  assign BUSY = state != IDLE;
  assign TX_D = state == SEND_LO ? result[DATA_WIDTH-1:0] :
                state == SEND_HI ? result[OUT_WIDTH-1:DATA_WIDTH] : '0;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed frames with a queue scoreboard on the TX byte stream
module tb_alu_cmd_sequencer;
  logic CLK = 0, RST = 0;
  logic [7:0] RX_D = 0;
  logic RX_D_VLD = 0;
  logic [3:0] ALU_FUN;
  logic [7:0] ALU_A, ALU_B, TX_D;
  logic ALU_EN, TX_D_VLD, BUSY, ERR;
  logic [15:0] alu_out;
  logic alu_vld;
  logic TX_READY = 1;
  logic alu_hang = 0;
  int pass_cnt = 0, tot_cnt = 0;
  int en_cnt = 0, err_cnt = 0;
  logic [7:0] exp_q[$];

  alu_cmd_sequencer dut (
    .CLK(CLK), .RST(RST), .RX_D(RX_D), .RX_D_VLD(RX_D_VLD),
    .ALU_FUN(ALU_FUN), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_EN(ALU_EN),
    .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_vld),
    .TX_D(TX_D), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // one-cycle registered ALU stub: 0 AND, 1 OR, 2 SUB, 3 ADD
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_vld <= 0;
      alu_out <= 0;
    end else begin
      alu_vld <= ALU_EN && !alu_vld && !alu_hang;
      case (ALU_FUN)
        4'd0: alu_out <= {8'h00, ALU_A & ALU_B};
        4'd1: alu_out <= {8'h00, ALU_A | ALU_B};
        4'd2: alu_out <= {8'h00, ALU_A} - {8'h00, ALU_B};
        4'd3: alu_out <= {8'h00, ALU_A} + {8'h00, ALU_B};
        default: alu_out <= 16'hDEAD;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (ALU_EN) en_cnt++;
    if (ERR) err_cnt++;
    if (RST && TX_D_VLD && TX_READY) begin
      if (exp_q.size() == 0) chk("tx_unexpected", {24'h0, TX_D}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'h0, TX_D}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    tick(1);
    RX_D = b;
    RX_D_VLD = 1;
    tick(1);
    RX_D_VLD = 0;
  endtask

  task automatic frame(input logic [7:0] op, a, b);
    send(op);
    send(a);
    send(b);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((BUSY || exp_q.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, {BUSY, 31'(exp_q.size())}, 32'h0);
  endtask

  function automatic logic [31:0] outs();
    return {ALU_FUN, ALU_A, ALU_B, TX_D, ALU_EN, TX_D_VLD, BUSY, ERR};
  endfunction

  initial begin
    int e0, n0;
    #2 chk("reset_outputs", outs(), 0);
    tick(1);
    RST = 1;
    // 1: AND, latency and operand registers
    exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
    frame(8'h00, 8'h0F, 8'h3C);
    chk("t1_operands", {12'h0, ALU_FUN, ALU_A, ALU_B}, {12'h0, 4'h0, 8'h0F, 8'h3C});
    chk("t1_en_after_b", {31'h0, ALU_EN}, 1);
    tick(2);
    chk("t1_tx_lo_latency", {23'h0, TX_D_VLD, TX_D}, {23'h0, 1'b1, 8'h0C});
    drain("t1_drain");
    // 2: stalled TX with zero result
    TX_READY = 0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    frame(8'h02, 8'hFF, 8'hFF);
    tick(2);
    n0 = en_cnt;
    tick(5);
    chk("t2_stall_hold", {22'h0, ALU_EN, TX_D_VLD, TX_D, BUSY}, {22'h0, 1'b0, 1'b1, 8'h00, 1'b1});
    chk("t2_en_during_stall", en_cnt - n0, 0);
    chk("t2_queue_untouched", exp_q.size(), 2);
    TX_READY = 1;
    drain("t2_drain");
    // 3: bad opcode then a normal OR frame
    e0 = err_cnt;
    send(8'h1F);
    chk("t3_busy_after_bad", {31'h0, BUSY}, 0);
    tick(2);
    chk("t3_err_pulse", err_cnt - e0, 1);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    frame(8'h01, 8'hAA, 8'h55);
    chk("t3_fun", {28'h0, ALU_FUN}, 1);
    drain("t3_drain");
    // 4: ALU never answers
    alu_hang = 1;
    e0 = err_cnt;
    n0 = en_cnt;
    frame(8'h03, 8'h11, 8'h22);
    tick(25);
    chk("t4_en_cycles", en_cnt - n0, 15);
    chk("t4_err_pulse", err_cnt - e0, 1);
    chk("t4_idle", {30'h0, BUSY, TX_D_VLD}, 0);
    alu_hang = 0;
    // 5: overrun in EXEC and in SEND_HI
    e0 = err_cnt;
    TX_READY = 0;
    exp_q.push_back(8'h90); exp_q.push_back(8'h00);
    frame(8'h03, 8'h40, 8'h50);
    send(8'h77);
    TX_READY = 1;
    tick(1);
    TX_READY = 0;
    send(8'h66);
    tick(1);
    chk("t5_hi_hold", {23'h0, TX_D_VLD, TX_D}, {23'h0, 1'b1, 8'h00});
    TX_READY = 1;
    drain("t5_drain");
    chk("t5_err_pulses", err_cnt - e0, 2);
    // 6: reset mid-frame and mid-send
    send(8'h00);
    send(8'h12);
    #1 RST = 0;
    #1 chk("t6_reset_get_b", outs(), 0);
    tick(1);
    RST = 1;
    TX_READY = 0;
    frame(8'h03, 8'h01, 8'h02);
    tick(3);
    chk("t6_in_send_lo", {23'h0, TX_D_VLD, TX_D}, {23'h0, 1'b1, 8'h03});
    #1 RST = 0;
    #1 chk("t6_reset_send_lo", outs(), 0);
    tick(1);
    RST = 1;
    TX_READY = 1;
    exp_q.push_back(8'h30); exp_q.push_back(8'h00);
    frame(8'h00, 8'hF0, 8'h3C);
    drain("t6_drain");
    tick(3);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
